// File: rtl/oam_dma_m.sv
// OAM DMA engine: a write to 0xFF46 copies XFER_LEN bytes from 0xXX00 into OAM at 0xFE00
// via read-then-write bus cycles; the bus address parks at 0xFFFF while idle.
module oam_dma_m #(
    parameter int READ_LATENCY = 1,   // >= 1
    parameter int XFER_LEN     = 160,
    parameter int START_DELAY  = 1    // >= 1
) (
    input  logic        clk,
    input  logic        rst,
    // register port driven by the MMU
    input  logic [15:0] mmio_dma_addr_select,
    input  logic [7:0]  mmio_dma_write_value,
    input  logic        mmio_dma_write_enable,
    output logic [7:0]  mmio_dma_read_out,
    // bus master port into the MMU
    output logic [15:0] dma_req_addr_select,
    output logic [7:0]  dma_req_write_value,
    output logic        dma_req_write_enable,
    input  logic [7:0]  dma_req_read_out,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

    localparam logic [8:0]  XFER_END   = 9'(XFER_LEN);
    localparam logic [7:0]  START_LAST = 8'(START_DELAY - 1);
    localparam logic [7:0]  READ_LAST  = 8'(READ_LATENCY);
    localparam logic [15:0] PARK_ADDR  = 16'hFFFF;

    state_t      state_reg;
    logic [7:0]  src_hi_reg;
    logic [7:0]  dma_reg;
    logic [7:0]  count_reg;
    logic [7:0]  wait_cnt_reg;
    logic        strobe_prev_reg;

    logic        strobe;
    logic        trigger;
    logic [7:0]  src_fold;
    logic [8:0]  count_inc;
    logic [15:0] dest_addr;

    // A held strobe is one register write: only its first cycle triggers.
    assign strobe    = mmio_dma_write_enable && (mmio_dma_addr_select == 16'hFF46);
    assign trigger   = strobe && !strobe_prev_reg;
    // E0-FF fold onto the WRAM echo so the source is always real memory.
    assign src_fold  = (mmio_dma_write_value > 8'hDF) ? (mmio_dma_write_value - 8'h20)
                                                      : mmio_dma_write_value;
    assign count_inc = {1'b0, count_reg} + 9'd1;
    assign dest_addr = 16'hFE00 + {8'h00, count_reg};

    assign mmio_dma_read_out = dma_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg            <= IDLE;
            src_hi_reg           <= 8'h00;
            dma_reg              <= 8'h00;
            count_reg            <= 8'h00;
            wait_cnt_reg         <= 8'h00;
            strobe_prev_reg      <= 1'b0;
            dma_req_addr_select  <= PARK_ADDR;
            dma_req_write_value  <= 8'h00;
            dma_req_write_enable <= 1'b0;
            busy                 <= 1'b0;
        end else begin
            strobe_prev_reg      <= strobe;
            dma_req_write_value  <= 8'h00;
            dma_req_write_enable <= 1'b0;
            if (trigger) begin
                // A new trigger pre-empts whatever is in flight, including a pending write.
                dma_reg             <= mmio_dma_write_value;
                src_hi_reg          <= src_fold;
                count_reg           <= 8'h00;
                wait_cnt_reg        <= 8'h00;
                state_reg           <= START;
                dma_req_addr_select <= PARK_ADDR;
                busy                <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        dma_req_addr_select <= PARK_ADDR;
                        busy                <= 1'b0;
                    end
                    START: begin
                        if (wait_cnt_reg == START_LAST) begin
                            wait_cnt_reg        <= 8'h00;
                            state_reg           <= READ;
                            dma_req_addr_select <= {src_hi_reg, count_reg};
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 8'd1;
                        end
                    end
                    READ: begin
                        // The address stays put because the MMU routes read data by it.
                        if (wait_cnt_reg == READ_LAST) begin
                            wait_cnt_reg         <= 8'h00;
                            state_reg            <= WRITE;
                            dma_req_addr_select  <= dest_addr;
                            dma_req_write_value  <= dma_req_read_out;
                            dma_req_write_enable <= 1'b1;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 8'd1;
                        end
                    end
                    WRITE: begin
                        if (count_inc == XFER_END) begin
                            state_reg           <= IDLE;
                            dma_req_addr_select <= PARK_ADDR;
                            busy                <= 1'b0;
                        end else begin
                            count_reg           <= count_inc[7:0];
                            state_reg           <= READ;
                            dma_req_addr_select <= {src_hi_reg, count_inc[7:0]};
                        end
                    end
                    default: begin
                        state_reg           <= IDLE;
                        dma_req_addr_select <= PARK_ADDR;
                        busy                <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_m.sv
// Directed bench for oam_dma_m: one engine at READ_LATENCY=1 and one at READ_LATENCY=2,
// each behind a small memory model whose read data lags the address by the latency.
module tb_oam_dma_m;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mmio_addr;
    logic [7:0]  mmio_wv;
    logic        mmio_we1;
    logic        mmio_we2;

    logic [7:0]  reg_out1, reg_out2;
    logic [15:0] addr1, addr2;
    logic [7:0]  wv1, wv2;
    logic        we1, we2;
    logic        busy1, busy2;
    logic [7:0]  mem_q1, mem_q2;
    logic [15:0] addr1_d1, addr2_d1, addr2_d2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // WRAM model: C000-DFFF hold lo^hi^9A (so C0xx = i^5A); everything else reads EE.
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return (a[15:13] == 3'b110) ? (a[7:0] ^ a[15:8] ^ 8'h9A) : 8'hEE;
    endfunction

    always @(posedge clk) begin
        addr1_d1 <= addr1;
        addr2_d1 <= addr2;
        addr2_d2 <= addr2_d1;
    end
    assign mem_q1 = mem_f(addr1_d1);
    assign mem_q2 = mem_f(addr2_d2);

    oam_dma_m #(.READ_LATENCY(1), .XFER_LEN(160), .START_DELAY(1)) dut1 (
        .clk                   (clk),
        .rst                   (rst),
        .mmio_dma_addr_select  (mmio_addr),
        .mmio_dma_write_value  (mmio_wv),
        .mmio_dma_write_enable (mmio_we1),
        .mmio_dma_read_out     (reg_out1),
        .dma_req_addr_select   (addr1),
        .dma_req_write_value   (wv1),
        .dma_req_write_enable  (we1),
        .dma_req_read_out      (mem_q1),
        .busy                  (busy1)
    );

    oam_dma_m #(.READ_LATENCY(2), .XFER_LEN(160), .START_DELAY(1)) dut2 (
        .clk                   (clk),
        .rst                   (rst),
        .mmio_dma_addr_select  (mmio_addr),
        .mmio_dma_write_value  (mmio_wv),
        .mmio_dma_write_enable (mmio_we2),
        .mmio_dma_read_out     (reg_out2),
        .dma_req_addr_select   (addr2),
        .dma_req_write_value   (wv2),
        .dma_req_write_enable  (we2),
        .dma_req_read_out      (mem_q2),
        .busy                  (busy2)
    );

    // Bus monitor: one sample per cycle, mid-cycle.
    int          busy_n1 = 0, busy_n2 = 0, wr_n1 = 0, wr_n2 = 0, rd_n2 = 0;
    int          f1_n = 0, d1_n = 0;
    logic [15:0] wr_a1 [0:2047];
    logic [7:0]  wr_d1 [0:2047];
    logic [15:0] wr_a2 [0:2047];
    logic [7:0]  wr_d2 [0:2047];

    always @(negedge clk) begin
        if (busy1) busy_n1 <= busy_n1 + 1;
        if (busy2) busy_n2 <= busy_n2 + 1;
        if (we1) begin
            if (wr_n1 < 2048) begin
                wr_a1[wr_n1] <= addr1;
                wr_d1[wr_n1] <= wv1;
            end
            wr_n1 <= wr_n1 + 1;
        end else if (addr1 != 16'hFFFF) begin
            if (addr1[15:8] == 8'hF1) f1_n <= f1_n + 1;
            if (addr1[15:8] == 8'hD1) d1_n <= d1_n + 1;
        end
        if (we2) begin
            if (wr_n2 < 2048) begin
                wr_a2[wr_n2] <= addr2;
                wr_d2[wr_n2] <= wv2;
            end
            wr_n2 <= wr_n2 + 1;
        end else if (addr2 != 16'hFFFF) begin
            rd_n2 <= rd_n2 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Write val to 0xFF46 of engine sel, holding the strobe for hold cycles.
    task automatic reg_write(input bit sel, input logic [7:0] val, input int hold);
        mmio_addr = 16'hFF46;
        mmio_wv   = val;
        if (sel) mmio_we2 = 1'b1;
        else     mmio_we1 = 1'b1;
        repeat (hold) step();
        mmio_we1  = 1'b0;
        mmio_we2  = 1'b0;
        mmio_addr = 16'h0000;
    endtask

    task automatic wait_idle(input bit sel, input string tag);
        int n;
        n = 0;
        while (((sel ? busy2 : busy1) == 1'b1) && n < 2000) begin
            step();
            n++;
        end
        chk(tag, {31'd0, (sel ? busy2 : busy1)}, 32'd0);
    endtask

    task automatic check_writes(input bit sel, input string tag, input int base, input int n,
                                input logic [7:0] xorv);
        logic [15:0] a;
        logic [7:0]  d;
        for (int i = 0; i < n; i++) begin
            a = sel ? wr_a2[base + i] : wr_a1[base + i];
            d = sel ? wr_d2[base + i] : wr_d1[base + i];
            chk(tag, {8'h00, a, d}, {8'h00, 16'hFE00 + 16'(i), 8'(i) ^ xorv});
        end
    endtask

    initial begin
        int b_busy, b_wr, b_f1, b_d1, b_rd, n;
        mmio_addr = 16'h0000;
        mmio_wv   = 8'h00;
        mmio_we1  = 1'b0;
        mmio_we2  = 1'b0;
        #1 rst = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_addr", addr1, 16'hFFFF);
        chk("rst_we", we1, 0);
        chk("rst_wv", wv1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_reg", reg_out1, 8'h00);
        chk("rst_addr2", addr2, 16'hFFFF);
        rst = 1'b1;
        repeat (2) step();

        // Basic copy C0xx -> OAM
        b_busy = busy_n1; b_wr = wr_n1;
        reg_write(0, 8'hC0, 1);
        wait_idle(0, "basic_done");
        chk("basic_park", addr1, 16'hFFFF);
        chk("basic_busy_cycles", busy_n1 - b_busy, 481);
        chk("basic_writes", wr_n1 - b_wr, 160);
        check_writes(0, "basic_wr", b_wr, 160, 8'h5A);
        chk("basic_reg", reg_out1, 8'hC0);

        // Echo fold: F1 reads from D1xx
        b_wr = wr_n1; b_f1 = f1_n; b_d1 = d1_n;
        reg_write(0, 8'hF1, 1);
        wait_idle(0, "echo_done");
        chk("echo_f1_reads", f1_n - b_f1, 0);
        chk("echo_d1_reads", d1_n - b_d1, 320);
        chk("echo_reg", reg_out1, 8'hF1);
        check_writes(0, "echo_wr", b_wr, 160, 8'h4B);

        // Held strobe for 5 cycles is a single write
        b_busy = busy_n1; b_wr = wr_n1;
        reg_write(0, 8'hC0, 5);
        wait_idle(0, "held_done");
        chk("held_busy_cycles", busy_n1 - b_busy, 481);
        chk("held_writes", wr_n1 - b_wr, 160);

        // Restart with D0 while byte 50 is being read
        b_busy = busy_n1; b_wr = wr_n1;
        reg_write(0, 8'hC0, 1);
        n = 0;
        while ((wr_n1 - b_wr) < 50 && n < 500) begin
            step();
            n++;
        end
        chk("restart_reach50", wr_n1 - b_wr, 50);
        step();
        reg_write(0, 8'hD0, 1);
        wait_idle(0, "restart_done");
        chk("restart_writes", wr_n1 - b_wr, 210);
        chk("restart_busy_cycles", busy_n1 - b_busy, 633);
        check_writes(0, "restart_old", b_wr, 50, 8'h5A);
        check_writes(0, "restart_new", b_wr + 50, 160, 8'h4A);

        // Trigger in the same cycle as the final write
        b_busy = busy_n1; b_wr = wr_n1;
        reg_write(0, 8'hC0, 1);
        n = 0;
        while ((wr_n1 - b_wr) < 160 && n < 1000) begin
            step();
            n++;
        end
        chk("coinc_last_we", we1, 1);
        reg_write(0, 8'hD0, 1);
        chk("coinc_busy", busy1, 1);
        chk("coinc_park_in_start", addr1, 16'hFFFF);
        wait_idle(0, "coinc_done");
        chk("coinc_writes", wr_n1 - b_wr, 320);
        chk("coinc_busy_cycles", busy_n1 - b_busy, 962);
        check_writes(0, "coinc_first", b_wr, 160, 8'h5A);
        check_writes(0, "coinc_second", b_wr + 160, 160, 8'h4A);

        // Asynchronous reset in the middle of a write cycle
        reg_write(0, 8'hC0, 1);
        repeat (198) step();
        chk("mid_busy", busy1, 1);
        chk("mid_we", we1, 1);
        rst = 1'b0;
        #1;
        chk("async_addr", addr1, 16'hFFFF);
        chk("async_we", we1, 0);
        chk("async_wv", wv1, 0);
        chk("async_busy", busy1, 0);
        chk("async_reg", reg_out1, 8'h00);
        step();
        rst = 1'b1;
        repeat (2) step();

        // READ_LATENCY=2 engine
        b_busy = busy_n2; b_wr = wr_n2; b_rd = rd_n2;
        reg_write(1, 8'hC0, 1);
        wait_idle(1, "lat2_done");
        chk("lat2_busy_cycles", busy_n2 - b_busy, 641);
        chk("lat2_writes", wr_n2 - b_wr, 160);
        chk("lat2_read_cycles", rd_n2 - b_rd, 480);
        check_writes(1, "lat2_wr", b_wr, 160, 8'h5A);
        chk("lat2_park", addr2, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/oam_dma_m.md
Name: oam_dma_m

Overview:
OAM DMA engine. It is the responder behind the MMU's DMA register port (0xFF46) and the initiator of the MMU's DMA request port. A CPU write of byte XX to 0xFF46 copies 160 bytes from source 0xXX00–0xXX9F to OAM 0xFE00–0xFE9F. It issues read-then-write bus cycles through the MMU, which gives DMA priority over the CPU. While idle, it parks its bus address at 0xFFFF; the MMU treats this as "no transfer ongoing" and uses it to gate CPU OAM access.

Parameters:
READ_LATENCY, 1, cycles from address presented to read_out valid through the MMU (must be ≥1)
XFER_LEN, 160, bytes per transfer
START_DELAY, 1, idle cycles between the trigger and the first read

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low
mmio_dma_if  mem_if.slave  -  register port driven by the MMU
  .addr_select  in  16; .write_value  in  8; .write_enable  in  1; .read_out  out  8
dma_req  mem_if.master  -  bus master port into the MMU
  .addr_select  out  16; .write_value  out  8; .write_enable  out  1; .read_out  in  8
busy  output  1  high while a transfer is in progress (START..WRITE)

Behaviour:
- Reset (rst low, async), taking effect immediately, including mid-transfer:
  - state=IDLE, src_hi=8'h00, dma_reg=8'h00, count=0
  - dma_req.addr_select=16'hFFFF, write_value=0, write_enable=0, busy=0
- Register port:
  - mmio_dma_if.read_out = dma_reg, combinational, always.
  - Trigger = mmio_dma_if.write_enable && addr_select==16'hFF46 in this cycle AND not in the previous cycle. A held strobe therefore counts as one write.
  - On trigger: dma_reg <= write_value; src_hi <= (write_value > 8'hDF) ? write_value - 8'h20 : write_value, so E0–FF fold onto the WRAM echo; count <= 0; state <= START.
- States:
  - IDLE: bus parked as in reset. Waits for trigger.
  - START: START_DELAY cycles with the bus parked. busy=1. Then go to READ.
  - READ: addr_select={src_hi, count[7:0]}, write_enable=0. Held for READ_LATENCY+1 cycles. The address must stay stable while data returns, because the MMU routes read_out by the current address. On the last READ cycle, latch dma_req.read_out into data_q, then go to WRITE.
  - WRITE: one cycle with addr_select=16'hFE00+count, write_value=data_q, write_enable=1. Then count <= count+1. If count+1==XFER_LEN, go to IDLE; else go to READ.
- Timing:
  - Per byte: READ_LATENCY+2 cycles. With defaults the whole transfer takes 1+160*3=481 cycles from the cycle after the trigger.
  - The final WRITE (to 0xFE9F) is followed by IDLE, with addr_select=16'hFFFF on the next cycle.
- count is 8-bit and never wraps past XFER_LEN-1. Source low byte = count. Destination = 0xFE00+count (0xFE00..0xFE9F).
- New trigger while busy:
  - Aborts the current transfer at the end of the current cycle; any pending WRITE is not issued.
  - Reloads src_hi and dma_reg, resets count to 0, and re-enters START.
- Trigger and final WRITE in the same cycle: the WRITE completes, then the engine goes to START with the new source, not IDLE.
- write_value/write_enable are 0 in every cycle except WRITE.
- busy=1 in START, READ and WRITE.

Test Plan:
- Reset checks: after reset, dma_req.addr_select=FFFF, we=0, busy=0, and reading 0xFF46 returns 00. Pulse rst low at cycle 200 of an active transfer → outputs return to the parked values asynchronously, without waiting for a clock edge.
- Basic copy: WRAM model with C000+i = i^0x5A, latency 1; write C0 to FF46 → 160 OAM writes FE00+i = i^0x5A; busy high for exactly 481 cycles; exactly one write_enable per byte.
- Echo fold: write F1 to FF46 → source addresses D100..D19F are issued (not F100); reading FF46 returns F1.
- Held strobe: hold write_enable with FF46 selected for 5 cycles → exactly one transfer starts; no restart occurs.
- Restart: write C0, then write D0 at byte 50 → no further writes from the C0 source occur; the new copy starts from D000 → FE00 and 160 more writes complete.
- Latency parameter: with READ_LATENCY=2 the source address is held 3 cycles per byte and data is sampled on the third; the transfer takes 1+160*4=641 cycles.
